// File: rtl/mult_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : mult_secuencial
// Purpose  : 4x4 unsigned shift-and-add multiplier driving an external adder.
// Revision : 1.0
// ============================================================================
module mult_secuencial #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_cin,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int STEP_W = $clog2(WIDTH);
   localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [WIDTH-1:0]    r_m;
   logic [WIDTH-1:0]    r_q;
   logic [WIDTH-1:0]    r_acc;
   logic [STEP_W-1:0]   r_step;
   logic [2*WIDTH-1:0]  r_product;
   logic                w_last;

   assign w_last = (r_step == C_LAST_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Each RUN step shifts {cout, sum, q} right by one; cout lands in acc MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m       <= '0;
         r_q       <= '0;
         r_acc     <= '0;
         r_step    <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m    <= op_a;
                  r_q    <= op_b;
                  r_acc  <= '0;
                  r_step <= '0;
               end
            end
            S_RUN: begin
               r_acc  <= {add_cout, add_sum[WIDTH-1:1]};
               r_q    <= {add_sum[0], r_q[WIDTH-1:1]};
               r_step <= r_step + 1'b1;
               if (w_last) begin
                  r_product <= {add_cout, add_sum, r_q[WIDTH-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   assign add_a   = r_acc;
   assign add_b   = ((r_state == S_RUN) && r_q[0]) ? r_m : '0;
   assign add_cin = 1'b0;
   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);
   assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_secuencial
// Purpose  : Self-checking bench for mult_secuencial with a behavioural adder.
// Revision : 1.0
// ============================================================================
module tb_mult_secuencial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_cin;
   logic [3:0] add_sum;
   logic       add_cout;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int         checks = 0;
   int         errors = 0;
   int         done_cnt = 0;
   logic [7:0] sb[$];
   logic [7:0] exp_held;
   logic [7:0] mon_exp;
   logic [3:0] bseq[8];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   // Neighbouring ripple-carry adder stage
   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   mult_secuencial #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .product  (product)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got product %0h expected no done at %0t", product, $time);
         end else begin
            mon_exp = sb.pop_front();
            chk("product", 32'(product), 32'(mon_exp));
         end
      end
   end

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
      int n;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      chk("held_product", 32'(product), 32'(exp_held));
      n = 0;
      while (busy && n < 8) begin
         bseq[n] = add_b;
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 4);
      chk("done_pulse", 32'(done), 1);
      @(negedge clk);
      chk("done_drop", 32'(done), 0);
      exp_held = exp;
   endtask

   initial begin
      int base;
      logic [7:0] last_e;
      vecs[0] = '{4'd7,  4'd3,  8'h15};
      vecs[1] = '{4'd15, 4'd15, 8'hE1};
      vecs[2] = '{4'd9,  4'd0,  8'h00};
      vecs[3] = '{4'd0,  4'd12, 8'h00};
      vecs[4] = '{4'd5,  4'd6,  8'h1E};
      vecs[5] = '{4'd1,  4'd1,  8'h01};
      vecs[6] = '{4'd15, 4'd1,  8'h0F};
      vecs[7] = '{4'd8,  4'd8,  8'h40};
      vecs[8] = '{4'd11, 4'd13, 8'h8F};

      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; exp_held = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",    32'(busy),    0);
      chk("rst_done",    32'(done),    0);
      chk("rst_product", 32'(product), 0);
      chk("rst_add_a",   32'(add_a),   0);
      chk("rst_add_b",   32'(add_b),   0);
      chk("rst_add_cin", 32'(add_cin), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd7, 4'd3, 8'h15);
      chk("addb_7x3_s0", 32'(bseq[0]), 7);
      chk("addb_7x3_s1", 32'(bseq[1]), 7);
      chk("addb_7x3_s2", 32'(bseq[2]), 0);
      chk("addb_7x3_s3", 32'(bseq[3]), 0);
      run_op(4'd9, 4'd0, 8'h00);
      chk("addb_9x0", 32'(bseq[0] | bseq[1] | bseq[2] | bseq[3]), 0);

      for (int i = 0; i < 9; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

      // start held high with operands changing every cycle
      base   = done_cnt;
      last_e = '0;
      start  = 1'b1;
      for (int k = 0; k < 18; k++) begin
         op_a = 4'($urandom_range(0, 15));
         op_b = 4'($urandom_range(0, 15));
         if (k % 6 == 0) begin
            last_e = 8'(op_a) * 8'(op_b);
            sb.push_back(last_e);
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("held_start_dones", done_cnt - base, 3);
      chk("held_start_sb", sb.size(), 0);
      exp_held = last_e;

      // reset in the middle of a 13*11 operation
      op_a = 4'd13; op_b = 4'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy",    32'(busy),    0);
      chk("midrst_done",    32'(done),    0);
      chk("midrst_product", 32'(product), 0);
      chk("midrst_add_a",   32'(add_a),   0);
      chk("midrst_add_b",   32'(add_b),   0);
      base = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_no_done", done_cnt - base, 0);
      exp_held = '0;
      run_op(4'd5, 4'd6, 8'h1E);

      base = done_cnt;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(4'(a), 4'(b), 8'(a * b));
      chk("exhaustive_dones", done_cnt - base, 256);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
